// File: rtl/blit_pkg.sv
// Shared types and constants for the blitter pixel-op stage.
package blit_pkg;

  localparam int unsigned BLIT_PIX_W = 8;

  typedef enum logic [1:0] {
    BLIT_COPY    = 2'd0,
    BLIT_KEY     = 2'd1,
    BLIT_FILL    = 2'd2,
    BLIT_INVFILL = 2'd3
  } blit_mode_t;

  // A key with the MSB set can never equal a zero-extended pixel.
  localparam logic [BLIT_PIX_W:0] BLIT_NO_KEY = {1'b1, BLIT_PIX_W'(0)};

endpackage

// File: rtl/blit_pixel_op_if.sv
// Beat streaming bus around the pixel-op stage: input side and output side.
interface blit_pixel_op_if #(
  parameter int unsigned ADDR_W = 26,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned LANES  = 4
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [ADDR_W-1:0]      in_addr;
  logic [LANES*PIX_W-1:0] in_data;
  logic [LANES-1:0]       in_wmask;

  logic                   out_valid;
  logic                   out_ready;
  logic [ADDR_W-1:0]      out_addr;
  logic [LANES*PIX_W-1:0] out_data;
  logic [LANES-1:0]       out_wmask;

  // Environment view: feeds beats in, consumes beats out.
  modport master (
    output in_valid, in_addr, in_data, in_wmask, out_ready,
    input  in_ready, out_valid, out_addr, out_data, out_wmask
  );

  // Stage view.
  modport slave (
    input  in_valid, in_addr, in_data, in_wmask, out_ready,
    output in_ready, out_valid, out_addr, out_data, out_wmask
  );

endinterface

// File: rtl/blit_skid_buffer.sv
// Two-entry skid buffer: output register plus one skid slot, order preserving,
// with a registered ready that never depends combinationally on i_ready.
module blit_skid_buffer #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ready,
  output logic         o_empty_c
);

  logic         r_out_valid, r_skid_valid, r_in_ready;
  logic [W-1:0] r_out_data, r_skid_data;
  logic         w_out_valid, w_skid_valid, w_fire;
  logic [W-1:0] w_out_data, w_skid_data;

  // i_valid is only asserted when a beat was accepted while o_ready was high.
  always_comb begin
    w_out_valid  = r_out_valid;
    w_out_data   = r_out_data;
    w_skid_valid = r_skid_valid;
    w_skid_data  = r_skid_data;
    w_fire       = r_out_valid & i_ready;
    if (w_fire && r_skid_valid) begin
      w_out_data   = r_skid_data;
      w_skid_valid = 1'b0;
    end else if (w_fire || !r_out_valid) begin
      w_out_valid = i_valid;
      if (i_valid) w_out_data = i_data;
    end else if (i_valid) begin
      w_skid_valid = 1'b1;
      w_skid_data  = i_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_in_ready   <= 1'b0;
    end else begin
      r_out_valid  <= w_out_valid;
      r_out_data   <= w_out_data;
      r_skid_valid <= w_skid_valid;
      r_skid_data  <= w_skid_data;
      r_in_ready   <= !w_skid_valid;
    end
  end

  assign o_ready   = r_in_ready;
  assign o_valid   = r_out_valid;
  assign o_data    = r_out_data;
  assign o_empty_c = !r_out_valid & !r_skid_valid;

endmodule

// File: rtl/blit_pixel_op.sv
// Multi-lane blitter pixel operation: per-lane copy/key/fill/invfill producing
// a write mask, drop of empty beats, skid-buffered output and write/drop stats.
module blit_pixel_op
  import blit_pkg::*;
#(
  parameter int unsigned ADDR_W = 26,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned LANES  = 4,
  parameter int unsigned STAT_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  blit_mode_t        cfg_mode,
  input  logic [PIX_W:0]    cfg_key,
  input  logic [PIX_W-1:0]  cfg_fg,
  input  logic              in_idle,
  output logic              out_idle,
  input  logic              stat_clear,
  output logic [STAT_W-1:0] stat_written,
  output logic [STAT_W-1:0] stat_dropped,
  blit_pixel_op_if.slave    bus
);

  localparam int unsigned PAY_W = ADDR_W + LANES * PIX_W + LANES;
  localparam int unsigned CNT_W = $clog2(LANES + 1);

  logic [LANES-1:0]       w_match, w_lane_mask;
  logic [LANES*PIX_W-1:0] w_lane_data;
  logic                   w_in_ready, w_accept, w_push, w_drop, w_fire, w_empty_c;
  logic [PAY_W-1:0]       w_out_payload;
  logic [CNT_W-1:0]       w_pop;
  logic [STAT_W:0]        w_written_sum;
  logic [STAT_W-1:0]      r_written, r_dropped;
  logic                   r_idle;

  // Per-lane colour-key compare and mode select.
  always_comb begin
    w_match     = '0;
    w_lane_mask = '0;
    w_lane_data = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_match[i] = ({1'b0, bus.in_data[i*PIX_W +: PIX_W]} == cfg_key);
      unique case (cfg_mode)
        BLIT_COPY: begin
          w_lane_mask[i]                 = bus.in_wmask[i];
          w_lane_data[i*PIX_W +: PIX_W] = bus.in_data[i*PIX_W +: PIX_W];
        end
        BLIT_KEY: begin
          w_lane_mask[i]                 = bus.in_wmask[i] & !w_match[i];
          w_lane_data[i*PIX_W +: PIX_W] = bus.in_data[i*PIX_W +: PIX_W];
        end
        BLIT_FILL: begin
          w_lane_mask[i]                 = bus.in_wmask[i] & !w_match[i];
          w_lane_data[i*PIX_W +: PIX_W] = cfg_fg;
        end
        BLIT_INVFILL: begin
          w_lane_mask[i]                 = bus.in_wmask[i] & w_match[i];
          w_lane_data[i*PIX_W +: PIX_W] = cfg_fg;
        end
      endcase
    end
  end

  assign w_accept = bus.in_valid & w_in_ready;
  assign w_push   = w_accept & (|w_lane_mask);
  assign w_drop   = w_accept & !(|w_lane_mask);

  blit_skid_buffer #(.W(PAY_W)) u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_valid   (w_push),
    .i_data    ({bus.in_addr, w_lane_data, w_lane_mask}),
    .o_ready   (w_in_ready),
    .o_valid   (bus.out_valid),
    .o_data    (w_out_payload),
    .i_ready   (bus.out_ready),
    .o_empty_c (w_empty_c)
  );

  assign bus.in_ready = w_in_ready;
  assign {bus.out_addr, bus.out_data, bus.out_wmask} = w_out_payload;
  assign w_fire = bus.out_valid & bus.out_ready;

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < LANES; i++) w_pop = w_pop + CNT_W'(bus.out_wmask[i]);
  end

  assign w_written_sum = {1'b0, r_written} + (STAT_W + 1)'(w_pop);

  // Saturating statistics; clear wins over any same-cycle increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_written <= '0;
      r_dropped <= '0;
      r_idle    <= 1'b1;
    end else begin
      r_idle <= in_idle & !bus.in_valid & w_empty_c;
      if (stat_clear) begin
        r_written <= '0;
        r_dropped <= '0;
      end else begin
        if (w_fire) r_written <= w_written_sum[STAT_W] ? '1 : w_written_sum[STAT_W-1:0];
        if (w_drop && (r_dropped != '1)) r_dropped <= r_dropped + STAT_W'(1);
      end
    end
  end

  assign stat_written = r_written;
  assign stat_dropped = r_dropped;
  assign out_idle     = r_idle;

endmodule

// File: tb/tb_blit_pixel_op.sv
// Directed bench for blit_pixel_op: lane ops, drop, backpressure, idle, reset, stats.
module tb_blit_pixel_op;
  import blit_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  blit_mode_t cfg_mode;
  logic [8:0] cfg_key;
  logic [7:0] cfg_fg;
  logic       in_idle, out_idle, stat_clear;
  logic [7:0] stat_written, stat_dropped;
  int         n_chk = 0, n_pass = 0, n_fail = 0;

  blit_pixel_op_if #(.ADDR_W(26), .PIX_W(8), .LANES(4)) bus ();

  blit_pixel_op #(.ADDR_W(26), .PIX_W(8), .LANES(4), .STAT_W(8)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cfg_mode     (cfg_mode),
    .cfg_key      (cfg_key),
    .cfg_fg       (cfg_fg),
    .in_idle      (in_idle),
    .out_idle     (out_idle),
    .stat_clear   (stat_clear),
    .stat_written (stat_written),
    .stat_dropped (stat_dropped),
    .bus          (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic v, input int addr, input logic [31:0] data, input logic [3:0] wm);
    bus.in_valid = v;
    bus.in_addr  = 26'(addr);
    bus.in_data  = data;
    bus.in_wmask = wm;
  endtask

  initial begin
    int unsigned exp_q[$];
    int unsigned e;
    int sent, got;

    cfg_mode = BLIT_COPY; cfg_key = 9'h000; cfg_fg = 8'h00;
    in_idle = 1'b0; stat_clear = 1'b0;
    bus.out_ready = 1'b1;
    beat(1'b0, 0, 32'h0, 4'h0);

    // Reset values
    #1 reset_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data", 64'({bus.out_addr, bus.out_data, bus.out_wmask}), 64'(0));
    chk("rst_out_idle", 64'(out_idle), 64'(1));
    chk("rst_stats", 64'({stat_written, stat_dropped}), 64'(0));
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("rel_in_ready", 64'(bus.in_ready), 64'(1));
    chk("busy_idle", 64'(out_idle), 64'(0));

    // KEY with a matching key on lanes 0 and 2
    cfg_mode = BLIT_KEY; cfg_key = 9'h00C;
    beat(1'b1, 1, 32'h220C110C, 4'hF);
    tick();
    chk("key_valid", 64'(bus.out_valid), 64'(1));
    chk("key_mask", 64'(bus.out_wmask), 64'(4'b1010));
    chk("key_data", 64'(bus.out_data), 64'(32'h220C110C));
    chk("key_addr", 64'(bus.out_addr), 64'(1));
    beat(1'b0, 0, 32'h0, 4'h0);
    tick();
    chk("key_written", 64'(stat_written), 64'(2));
    chk("key_drained", 64'(bus.out_valid), 64'(0));

    // Disabled key, then an all-masked COPY beat that must be dropped
    cfg_key = 9'h10C;
    beat(1'b1, 2, 32'h220C110C, 4'hF);
    tick();
    chk("nokey_mask", 64'(bus.out_wmask), 64'(4'b1111));
    cfg_mode = BLIT_COPY;
    beat(1'b1, 3, 32'h12345678, 4'h0);
    tick();
    beat(1'b0, 0, 32'h0, 4'h0);
    chk("drop_valid", 64'(bus.out_valid), 64'(0));
    chk("drop_count", 64'(stat_dropped), 64'(1));
    chk("drop_written", 64'(stat_written), 64'(6));

    // FILL then INVFILL back to back
    cfg_mode = BLIT_FILL; cfg_key = 9'h000; cfg_fg = 8'h55;
    beat(1'b1, 4, 32'h09000700, 4'hF);
    tick();
    chk("fill_mask", 64'(bus.out_wmask), 64'(4'b1010));
    chk("fill_data", 64'(bus.out_data), 64'(32'h55555555));
    cfg_mode = BLIT_INVFILL;
    tick();
    chk("inv_mask", 64'(bus.out_wmask), 64'(4'b0101));
    chk("inv_data", 64'(bus.out_data), 64'(32'h55555555));
    beat(1'b0, 0, 32'h0, 4'h0);
    tick();
    chk("fill_written", 64'(stat_written), 64'(10));

    // Backpressure: 8 beats, out_ready low for cycles 2..5
    cfg_mode = BLIT_COPY; cfg_key = BLIT_NO_KEY;
    sent = 0; got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      beat(sent < 8, sent, {4{8'(sent)}}, 4'hF);
      bus.out_ready = !(c >= 2 && c <= 5);
      if (c >= 3 && c <= 5) begin
        chk("stall_valid", 64'(bus.out_valid), 64'(1));
        chk("stall_addr", 64'(bus.out_addr), 64'(1));
        chk("stall_data", 64'(bus.out_data), 64'(32'h01010101));
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(sent);
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("bp_spurious", 64'(1), 64'(0));
        else begin
          e = exp_q.pop_front();
          chk("bp_addr", 64'(bus.out_addr), 64'(e));
          chk("bp_data", 64'(bus.out_data), 64'({4{8'(e)}}));
        end
        got++;
      end
      tick();
      chk("bp_in_ready", 64'(bus.in_ready), 64'((c >= 2 && c <= 5) ? 0 : 1));
    end
    beat(1'b0, 0, 32'h0, 4'h0);
    bus.out_ready = 1'b1;
    chk("bp_got", 64'(got), 64'(8));
    chk("bp_written", 64'(stat_written), 64'(42));

    // Idle, then reset in the middle of a stall
    in_idle = 1'b1;
    tick(); tick();
    chk("idle_set", 64'(out_idle), 64'(1));
    bus.out_ready = 1'b0;
    beat(1'b1, 32, 32'hA0A0A0A0, 4'hF);
    tick();
    chk("idle_clr", 64'(out_idle), 64'(0));
    beat(1'b1, 33, 32'hA1A1A1A1, 4'hF);
    tick();
    beat(1'b0, 0, 32'h0, 4'h0);
    chk("full_ready", 64'(bus.in_ready), 64'(0));
    chk("full_addr", 64'(bus.out_addr), 64'(32));
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.out_valid), 64'(0));
    chk("arst_ready", 64'(bus.in_ready), 64'(0));
    chk("arst_stats", 64'({stat_written, stat_dropped}), 64'(0));
    chk("arst_idle", 64'(out_idle), 64'(1));
    #4 reset_n = 1'b1;
    bus.out_ready = 1'b1;
    in_idle = 1'b0;
    tick();
    chk("rel2_ready", 64'(bus.in_ready), 64'(1));
    for (int k = 0; k < 4; k++) begin
      chk("no_replay", 64'(bus.out_valid), 64'(0));
      tick();
    end

    // Saturation of both counters
    cfg_mode = BLIT_FILL; cfg_key = BLIT_NO_KEY; cfg_fg = 8'hAA;
    for (int k = 0; k < 70; k++) begin
      beat(1'b1, k, 32'h0, 4'hF);
      tick();
    end
    beat(1'b0, 0, 32'h0, 4'h0);
    tick(); tick();
    chk("sat_written", 64'(stat_written), 64'(8'hFF));
    cfg_mode = BLIT_COPY;
    for (int k = 0; k < 260; k++) begin
      beat(1'b1, k, 32'h0, 4'h0);
      tick();
    end
    beat(1'b0, 0, 32'h0, 4'h0);
    tick();
    chk("sat_dropped", 64'(stat_dropped), 64'(8'hFF));
    chk("sat_written_hold", 64'(stat_written), 64'(8'hFF));

    // Clear coinciding with an output fire and a drop
    cfg_mode = BLIT_FILL;
    beat(1'b1, 48, 32'h0, 4'hF);
    tick();
    cfg_mode = BLIT_COPY;
    beat(1'b1, 49, 32'h0, 4'h0);
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    beat(1'b0, 0, 32'h0, 4'h0);
    chk("clr_written", 64'(stat_written), 64'(0));
    chk("clr_dropped", 64'(stat_dropped), 64'(0));
    chk("clr_valid", 64'(bus.out_valid), 64'(0));
    cfg_mode = BLIT_FILL;
    beat(1'b1, 50, 32'h0, 4'hF);
    tick();
    chk("post_clr_data", 64'(bus.out_data), 64'(32'hAAAAAAAA));
    beat(1'b0, 0, 32'h0, 4'h0);
    tick();
    chk("post_clr_written", 64'(stat_written), 64'(4));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/blit_pixel_op.md
Name: blit_pixel_op

Overview:
Parametrised multi-lane successor to the blitter's single-pixel transparency stage. It sits between the blitter's source-fetch stage and its memory-write stage. Each beat carries LANES pixels; the stage applies a per-lane pixel operation (copy / colour-key / solid fill / inverse fill) that produces a per-lane write mask. Beats with no surviving lane are dropped. Unlike the previous stage, it supports valid/ready backpressure through a 2-entry skid buffer and keeps write/drop statistics.

Parameters:
ADDR_W, 26, beat address width
PIX_W, 8, bits per pixel
LANES, 4, pixels per beat
STAT_W, 32, statistics counter width

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cfg_mode  in  2  pixel op, blit_pkg::blit_mode_t
cfg_key  in  PIX_W+1  colour key; MSB=1 means "no key" (never matches)
cfg_fg  in  PIX_W  foreground colour for fill modes
in_valid  in  1  input beat valid
in_ready  out  1  stage can accept a beat
in_addr  in  ADDR_W  beat address
in_data  in  LANES*PIX_W  pixels; lane i = bits [i*PIX_W +: PIX_W]
in_wmask  in  LANES  upstream lane enables
in_idle  in  1  upstream has no work
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_addr  out  ADDR_W  beat address
out_data  out  LANES*PIX_W  resulting pixels
out_wmask  out  LANES  lane write enables
out_idle  out  1  this stage and upstream are idle
stat_clear  in  1  synchronous clear of statistics
stat_written  out  STAT_W  lanes written (saturating)
stat_dropped  out  STAT_W  beats dropped (saturating)

Behaviour:
- One clock domain. reset_n is asynchronous and active-low: all registers clear immediately on assertion. Release is synchronous to clock.
- Reset values: in_ready=0 during reset, then 1 on the first clock after release. out_valid=0, out_addr/out_data/out_wmask=0, out_idle=1, both stats=0.
- Lane match: match_i = ({1'b0,pix_i} == cfg_key). Comparison is PIX_W+1 bits wide, so a key with MSB set never matches.
- Modes, per lane i, with m_i = in_wmask[i]:
  - COPY(0): mask=m_i; data=pix_i.
  - KEY(1): mask=m_i & !match_i; data=pix_i.
  - FILL(2): mask=m_i & !match_i; data=cfg_fg.
  - INVFILL(3): mask=m_i & match_i; data=cfg_fg.
- Masked-off lanes pass their computed data unchanged; downstream ignores them.
- Config is sampled on the cycle a beat is accepted (in_valid & in_ready). Changing cfg_* mid-transfer affects only later beats.
- Drop: an accepted beat whose computed mask is all-zero is consumed, never emitted, and increments stat_dropped.
- Latency: 1 cycle from acceptance to out_valid when not stalled. Throughput is 1 beat/clock.
- Skid buffer: an output register plus a skid register.
  - in_ready = !skid_valid (registered, no combinational path from out_ready).
  - An accepted surviving beat goes to the output register if it is empty or firing this cycle; otherwise it goes to skid.
  - When out fires and skid is valid, skid moves to the output register.
  - Order is always preserved.
  - Output holds stable while out_valid & !out_ready.
- Simultaneous accept + output fire with skid empty: the new beat replaces the output register and no skid is used.
- out_idle (registered) = in_idle & !in_valid & output register empty & skid empty.
- Statistics:
  - stat_written += popcount(out_wmask) on each output fire.
  - stat_dropped += 1 per dropped beat.
  - Both saturate at all-ones.
  - stat_clear zeroes both counters and takes priority over increments in the same cycle.
- Reset mid-transfer discards any buffered beats; nothing is replayed.

Decomposition:
- blit_pkg:
  - typedef enum logic [1:0] blit_mode_t {BLIT_COPY, BLIT_KEY, BLIT_FILL, BLIT_INVFILL}.
  - Constant BLIT_NO_KEY = {1'b1, PIX_W'(0)}.
- Sub-module blit_skid_buffer, parametrised by payload width (ADDR_W + LANES*PIX_W + LANES). It owns the valid/ready, skid and ordering logic.
- blit_pixel_op holds the lane operation, drop decision, idle and statistics logic.

Test Plan:
- KEY, key=0x00C, data lanes {0x0C,0x11,0x0C,0x22}, wmask=1111, out_ready=1 -> next cycle out_wmask=1010, data unchanged; stat_written=2.
- KEY, key=0x1_0C (no-key MSB set), same data -> out_wmask=1111. Then COPY with wmask=0000 -> beat dropped, out_valid stays 0, stat_dropped=1.
- FILL fg=0x55, key=0x000, data {0x00,0x07,0x00,0x09} -> out_data lanes 1,3=0x55, out_wmask=1010. INVFILL with same inputs -> out_wmask=0101.
- Backpressure: stream 8 beats (addr 0..7) with out_ready low for cycles 2-5 -> in_ready drops after 2 beats are buffered; all 8 emerge in order with no loss or duplication; output stays stable while stalled.
- Idle/reset: in_idle=1 with empty pipe -> out_idle=1. Pulse reset_n low mid-stall -> out_valid=0 and stats=0 immediately (asynchronous), and buffered beats never appear.
- Stats: preload near saturation via a long FILL run; assert stat_clear in the same cycle as a fire -> counter reads 0; saturation holds at all-ones.
